// File: rtl/weight_fetch_skew.sv
`default_nettype none
// ============================================================================
// Module   : weight_fetch_skew
// Purpose  : Accepts one vector of LANES weight-store read addresses per cycle.
//            It reads the addressed bytes from an on-block weight SRAM and
//            applies a diagonal skew: lane i reaches its output i cycles after
//            lane 0. A byte-wide host write port fills the store.
//            Backpressure from the array (io_outReady) freezes the whole
//            pipeline.
// Ports    : clock/reset       - single rising-edge clock, sync active-high reset
//            io_enable/io_rdAddr/io_addrValid/io_addrReady - address vector in
//            io_wrEn/io_wrAddr/io_wrData                   - weight store fill
//            io_outWeight/io_outValid/io_outReady          - skewed weights out
//            io_busy           - any valid lane held in the pipeline
//            io_addrErr        - sticky out-of-range read flag
// Options  : WFS_PERF_CNT_EN   - adds io_vecCount and io_stallCycles counters
// Revision : 1.0 - initial release
// ============================================================================
module weight_fetch_skew #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 9408
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_enable,
    input  logic [LANES*ADDR_W-1:0] io_rdAddr,
    input  logic [LANES-1:0]        io_addrValid,
    output logic                    io_addrReady,
    input  logic                    io_wrEn,
    input  logic [ADDR_W-1:0]       io_wrAddr,
    input  logic [DATA_W-1:0]       io_wrData,
    output logic [LANES*DATA_W-1:0] io_outWeight,
    output logic [LANES-1:0]        io_outValid,
    input  logic                    io_outReady,
    output logic                    io_busy,
    output logic                    io_addrErr
`ifdef WFS_PERF_CNT_EN
    ,
    output logic [31:0]             io_vecCount,
    output logic [31:0]             io_stallCycles
`endif
);

    localparam int                c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

    // Weight store: not reset, contents survive reset.
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic             w_accept;
    logic [LANES-1:0] w_laneBusy;
    logic [LANES-1:0] w_laneErr;
    logic             addrErr_q;

    // The whole pipeline advances in lock-step with the array, so the
    // generator may only hand over a vector when the array can advance.
    assign io_addrReady = io_outReady;
    assign w_accept     = io_enable & io_outReady;

    // Non-blocking write at the same edge as the stage-0 read gives
    // read-first behaviour on an address collision.
    always_ff @(posedge clock) begin
        if (io_wrEn && (io_wrAddr < c_DEPTH)) begin
            mem_q[io_wrAddr[c_IDX_W-1:0]] <= io_wrData;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ADDR_W-1:0] w_addr;
        logic              w_inRange;
        logic              w_rdVld;
        logic [DATA_W-1:0] w_rdData;
        // Index 0 is the read stage; indices 1..gi form the skew chain.
        logic [DATA_W-1:0] data_q [0:gi];
        logic [gi:0]       vld_q;

        assign w_addr    = io_rdAddr[gi*ADDR_W +: ADDR_W];
        assign w_inRange = (w_addr < c_DEPTH);
        // With io_enable low the read stage loads an aligned bubble.
        assign w_rdVld   = io_enable & io_addrValid[gi];
        assign w_rdData  = (w_rdVld && w_inRange) ? mem_q[w_addr[c_IDX_W-1:0]]
                                                  : '0;
        assign w_laneErr[gi] = w_rdVld & ~w_inRange;

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int j = 0; j <= gi; j++) begin
                    data_q[j] <= '0;
                end
                vld_q <= '0;
            end else if (io_outReady) begin
                data_q[0] <= w_rdData;
                vld_q[0]  <= w_rdVld;
                for (int j = 1; j <= gi; j++) begin
                    data_q[j] <= data_q[j-1];
                    vld_q[j]  <= vld_q[j-1];
                end
            end
        end

        assign io_outWeight[gi*DATA_W +: DATA_W] = data_q[gi];
        assign io_outValid[gi]                   = vld_q[gi];
        assign w_laneBusy[gi]                    = |vld_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addrErr_q <= 1'b0;
        end else if (w_accept && (|w_laneErr)) begin
            addrErr_q <= 1'b1;
        end
    end

    assign io_addrErr = addrErr_q;
    assign io_busy    = |w_laneBusy;

`ifdef WFS_PERF_CNT_EN
    logic [31:0] vecCount_q;
    logic [31:0] stallCycles_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            vecCount_q    <= '0;
            stallCycles_q <= '0;
        end else begin
            if (w_accept && (vecCount_q != 32'hFFFF_FFFF)) begin
                vecCount_q <= vecCount_q + 32'd1;
            end
            if (io_busy && !io_outReady && (stallCycles_q != 32'hFFFF_FFFF)) begin
                stallCycles_q <= stallCycles_q + 32'd1;
            end
        end
    end

    assign io_vecCount    = vecCount_q;
    assign io_stallCycles = stallCycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_skew.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_fetch_skew
// Purpose  : Self-checking bench for weight_fetch_skew. The reference model
//            records what the read stage captures at each pipeline advance.
//            Lane i's output is then the capture from i advances ago.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_skew;

    localparam int LANES  = 16;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 9408;
    localparam int AV_W   = LANES * ADDR_W;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    io_enable;
    logic [AV_W-1:0]         io_rdAddr;
    logic [LANES-1:0]        io_addrValid;
    logic                    io_addrReady;
    logic                    io_wrEn;
    logic [ADDR_W-1:0]       io_wrAddr;
    logic [DATA_W-1:0]       io_wrData;
    logic [LANES*DATA_W-1:0] io_outWeight;
    logic [LANES-1:0]        io_outValid;
    logic                    io_outReady;
    logic                    io_busy;
    logic                    io_addrErr;

    always #5 clock = ~clock;

    weight_fetch_skew #(
        .LANES (LANES),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_enable   (io_enable),
        .io_rdAddr   (io_rdAddr),
        .io_addrValid(io_addrValid),
        .io_addrReady(io_addrReady),
        .io_wrEn     (io_wrEn),
        .io_wrAddr   (io_wrAddr),
        .io_wrData   (io_wrData),
        .io_outWeight(io_outWeight),
        .io_outValid (io_outValid),
        .io_outReady (io_outReady),
        .io_busy     (io_busy),
        .io_addrErr  (io_addrErr)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state.
    logic [7:0]   mem_m  [DEPTH];
    logic [127:0] hist_d [64];   // read-stage data captured at advance n
    logic [15:0]  hist_v [64];   // read-stage valids captured at advance n
    int           adv     = 0;   // number of pipeline advances so far
    int           rst_adv = 0;   // advance count at the most recent reset
    logic         err_m   = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [AV_W-1:0] a,
                        input logic [15:0] v, input logic rdy, input logic we,
                        input logic [ADDR_W-1:0] wa, input logic [7:0] wd);
        logic [127:0] ew;
        logic [15:0]  ev;
        logic         eb;
        int           ai;
        int           idx;
        reset        = r;
        io_enable    = en;
        io_rdAddr    = a;
        io_addrValid = v;
        io_outReady  = rdy;
        io_wrEn      = we;
        io_wrAddr    = wa;
        io_wrData    = wd;
        #1;
        chk("addrReady", 128'(io_addrReady), 128'(rdy));
        @(posedge clock);
        if (r) begin
            rst_adv = adv;
            err_m   = 1'b0;
        end else if (rdy) begin
            adv++;
            ew = '0;
            ev = '0;
            for (int i = 0; i < LANES; i++) begin
                ai = int'(a[i*ADDR_W +: ADDR_W]);
                if (en && v[i]) begin
                    ev[i] = 1'b1;
                    if (ai < DEPTH) ew[i*8 +: 8] = mem_m[ai];
                    else            err_m = 1'b1;
                end
            end
            hist_d[adv % 64] = ew;
            hist_v[adv % 64] = ev;
        end
        // Applied after the read above: old data wins on a collision.
        if (we && (int'(wa) < DEPTH)) mem_m[int'(wa)] = wd;
        #1;
        ew = '0;
        ev = '0;
        eb = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j <= i; j++) begin
                idx = adv - j;
                if (idx > rst_adv) begin
                    if (j == i) begin
                        ew[i*8 +: 8] = hist_d[idx % 64][i*8 +: 8];
                        ev[i]        = hist_v[idx % 64][i];
                    end
                    if (hist_v[idx % 64][i]) eb = 1'b1;
                end
            end
        end
        chk("outWeight", io_outWeight, ew);
        chk("outValid", 128'(io_outValid), 128'(ev));
        chk("busy", 128'(io_busy), 128'(eb));
        chk("addrErr", 128'(io_addrErr), 128'(err_m));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, ADDR_W'(a), d);
    endtask

    task automatic vec(input logic [AV_W-1:0] a, input logic [15:0] v);
        step(1'b0, 1'b1, a, v, 1'b1, 1'b0, '0, '0);
    endtask

    function automatic logic [AV_W-1:0] seq(input int base);
        logic [AV_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ADDR_W +: ADDR_W] = ADDR_W'(base + i);
        return r;
    endfunction

    initial begin
        logic [AV_W-1:0] av;
        logic [ADDR_W-1:0] wa;

        // Reset state.
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

        // Fill the whole store with random bytes, then a[7:0] over 0..255.
        for (int a = 0; a < DEPTH; a++) wr(a, 8'($urandom));
        for (int a = 0; a < 256; a++) wr(a, 8'(a));

        // Identity vector across all lanes.
        vec(seq(0), 16'hFFFF);
        idle(20);

        // Upper half of the lanes invalid.
        vec(seq(100), 16'h00FF);
        idle(20);

        // Stall of three cycles, starting two cycles after acceptance.
        vec(seq(200), 16'hFFFF);
        idle(1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, seq(500), 16'hFFFF, 1'b0, 1'b0, '0, '0);
        idle(20);

        // Read-first on a same-cycle write collision.
        wr(7, 8'h11);
        step(1'b0, 1'b1, seq(7 - 0) & ~AV_W'(0) , 16'h0001, 1'b1, 1'b1, ADDR_W'(7), 8'hAA);
        idle(1);
        vec(seq(7), 16'h0001);
        idle(20);

        // Out-of-range lane 5; error flag must stay set while idle.
        av = seq(300);
        av[5*ADDR_W +: ADDR_W] = ADDR_W'(DEPTH);
        vec(av, 16'hFFFF);
        idle(25);

        // Out-of-range write is dropped and raises no error.
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        wr(DEPTH, 8'h5A);
        vec(seq(DEPTH - 16), 16'hFFFF);
        idle(20);

        // Reset in the middle of a back-to-back stream.
        vec(seq(1000), 16'hFFFF);
        vec(seq(2000), 16'hFFFF);
        step(1'b1, 1'b1, seq(3000), 16'hFFFF, 1'b1, 1'b0, '0, '0);
        vec(seq(4000), 16'hFFFF);
        vec(seq(5000), 16'hF0F0);
        idle(20);

        // Randomized traffic with stalls, collisions and occasional resets.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 31) == 0)
                    av[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
                else
                    av[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
            end
            case ($urandom_range(0, 3))
                0:       wa = av[0 +: ADDR_W];
                1:       wa = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
                default: wa = ADDR_W'($urandom_range(0, DEPTH - 1));
            endcase
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), av,
                 16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                 wa, 8'($urandom));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
